// File: rtl/m_btb_pkg.sv
// btb_pkg: shared constants and helpers for the branch target buffer.
//   - f_idx_w      : index width from the entry count (clog2)
//   - f_ctr_init   : weakly-taken counter value 2^(ctr_w-1)
//   - f_ctr_max    : upper counter saturation limit 2^ctr_w-1
//   - f_pc_idx     : table index from a PC (word-aligned, bits [idx_w+1:2])
//   - f_pc_tag     : stored tag from a PC (bits above the index)
//   - NOP_INSN / HALT_INSN : instruction encodings used by stimulus
// Optional build macro: BTB_BYPASS_EN (see m_btb).
package btb_pkg;

    // PCs are widened to this width before being handed to the helpers.
    localparam int unsigned BTB_FN_W = 64;

    localparam int unsigned CTR_MIN  = 0;

    localparam logic [31:0] NOP_INSN  = {25'd0, 7'b0010011};
    localparam logic [31:0] HALT_INSN = 32'h000f0033;

    function automatic int unsigned f_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned f_ctr_init(input int unsigned ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    function automatic int unsigned f_ctr_max(input int unsigned ctr_w);
        return (1 << ctr_w) - 1;
    endfunction

    function automatic logic [31:0] f_pc_idx(input logic [BTB_FN_W-1:0] pc,
                                             input int unsigned       idx_w);
        logic [BTB_FN_W-1:0] s;
        s = pc >> 2;
        return s[31:0] & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] f_pc_tag(input logic [BTB_FN_W-1:0] pc,
                                             input int unsigned       idx_w,
                                             input int unsigned       tag_w);
        logic [BTB_FN_W-1:0] s;
        s = pc >> (idx_w + 2);
        return s[31:0] & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/m_btb_if.sv
// m_btb_if: lookup / update / flush bus of the branch target buffer.
//   master : IF/ID/EX1 side (drives lookup PC, update, flush, enable)
//   slave  : the BTB (returns registered lookup result)
// Handshake: no back-pressure. w_up_valid and w_flush are single-cycle
// strobes sampled at each posedge where w_ce is high; r_lk_* are valid
// one enabled cycle after w_lk_pc was presented.
interface m_btb_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              w_ce;
    logic [ADDR_W-1:0] w_lk_pc;
    logic              r_lk_hit;
    logic              r_lk_taken;
    logic [ADDR_W-1:0] r_lk_target;
    logic              w_up_valid;
    logic [ADDR_W-1:0] w_up_pc;
    logic              w_up_taken;
    logic [ADDR_W-1:0] w_up_target;
    logic              w_flush;

    modport master (
        output w_ce, w_lk_pc, w_up_valid, w_up_pc, w_up_taken, w_up_target, w_flush,
        input  r_lk_hit, r_lk_taken, r_lk_target
    );

    modport slave (
        input  w_ce, w_lk_pc, w_up_valid, w_up_pc, w_up_taken, w_up_target, w_flush,
        output r_lk_hit, r_lk_taken, r_lk_target
    );
endinterface

// File: rtl/m_btb_sat_ctr.sv
// m_sat_ctr: combinational next value of a saturating direction counter.
//   ctr   : current counter
//   taken : resolved outcome (1 = count up, 0 = count down)
//   nxt   : next counter, clamped to [0, 2^CTR_W-1]
module m_sat_ctr
    import btb_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] nxt
);
    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(f_ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] CTR_LO  = CTR_W'(CTR_MIN);

    always_comb begin
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) nxt = ctr + 1'b1;
        end else begin
            if (ctr != CTR_LO) nxt = ctr - 1'b1;
        end
    end
endmodule

// File: rtl/m_btb.sv
// m_btb: direct-mapped tagged branch target buffer for the IF stage.
//   w_clk   : clock
//   w_rst_n : asynchronous active-low reset (clears valid bits and outputs)
//   bus     : m_btb_if.slave (lookup PC in, registered prediction out,
//             resolved-branch update, flush, clock enable)
// Each entry holds a tag, a target and a CTR_W-bit saturating counter.
// Lookup result appears one enabled cycle later. Build macro
// BTB_BYPASS_EN forwards a same-cycle update to a lookup of the same
// index; without it the lookup sees the table before the update.
module m_btb
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CTR_W   = 2
) (
    input  logic   w_clk,
    input  logic   w_rst_n,
    m_btb_if.slave bus
);
    localparam int unsigned      IDX_W    = f_idx_w(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(f_ctr_init(CTR_W));

    logic [TAG_W-1:0]  tag_mem [ENTRIES];
    logic [ADDR_W-1:0] tgt_mem [ENTRIES];
    logic [CTR_W-1:0]  ctr_mem [ENTRIES];
    logic [ENTRIES-1:0] valid_q;

    logic [31:0]       lk_idx_f, lk_tag_f, up_idx_f, up_tag_f;
    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;

    assign lk_idx_f = f_pc_idx(BTB_FN_W'(bus.w_lk_pc), IDX_W);
    assign lk_tag_f = f_pc_tag(BTB_FN_W'(bus.w_lk_pc), IDX_W, TAG_W);
    assign up_idx_f = f_pc_idx(BTB_FN_W'(bus.w_up_pc), IDX_W);
    assign up_tag_f = f_pc_tag(BTB_FN_W'(bus.w_up_pc), IDX_W, TAG_W);
    assign lk_idx   = lk_idx_f[IDX_W-1:0];
    assign lk_tag   = lk_tag_f[TAG_W-1:0];
    assign up_idx   = up_idx_f[IDX_W-1:0];
    assign up_tag   = up_tag_f[TAG_W-1:0];

    // Update path: read the addressed entry and build its post-update image.
    logic             up_hit, up_wr, up_en;
    logic [CTR_W-1:0] ctr_nxt;
    logic             pu_valid;
    logic [TAG_W-1:0] pu_tag;
    logic [ADDR_W-1:0] pu_tgt;
    logic [CTR_W-1:0] pu_ctr;

    assign up_hit = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);

    m_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
        .ctr   (ctr_mem[up_idx]),
        .taken (bus.w_up_taken),
        .nxt   (ctr_nxt)
    );

    always_comb begin
        pu_valid = valid_q[up_idx];
        pu_tag   = tag_mem[up_idx];
        pu_tgt   = tgt_mem[up_idx];
        pu_ctr   = ctr_mem[up_idx];
        up_wr    = 1'b0;
        if (bus.w_up_valid) begin
            if (up_hit) begin
                up_wr  = 1'b1;
                pu_ctr = ctr_nxt;
                if (bus.w_up_taken) pu_tgt = bus.w_up_target;
            end else if (bus.w_up_taken) begin
                // Miss + taken: allocate, evicting whatever aliased here.
                up_wr    = 1'b1;
                pu_valid = 1'b1;
                pu_tag   = up_tag;
                pu_tgt   = bus.w_up_target;
                pu_ctr   = CTR_INIT;
            end
        end
    end

    // Flush wins over a same-cycle update.
    assign up_en = bus.w_ce && !bus.w_flush && up_wr;

    always_ff @(posedge w_clk) begin
        if (up_en) begin
            tag_mem[up_idx] <= pu_tag;
            tgt_mem[up_idx] <= pu_tgt;
            ctr_mem[up_idx] <= pu_ctr;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            valid_q <= '0;
        end else if (bus.w_ce) begin
            if (bus.w_flush)  valid_q <= '0;
            else if (up_en)   valid_q[up_idx] <= pu_valid;
        end
    end

    // Lookup path: entry as seen by the lookup (optionally forwarded).
    logic              rd_valid, lk_hit_d, lk_taken_d;
    logic [TAG_W-1:0]  rd_tag;
    logic [ADDR_W-1:0] rd_tgt, lk_tgt_d;
    logic [CTR_W-1:0]  rd_ctr;

    always_comb begin
        rd_valid = valid_q[lk_idx];
        rd_tag   = tag_mem[lk_idx];
        rd_tgt   = tgt_mem[lk_idx];
        rd_ctr   = ctr_mem[lk_idx];
`ifdef BTB_BYPASS_EN
        if (bus.w_up_valid && (up_idx == lk_idx)) begin
            rd_valid = pu_valid;
            rd_tag   = pu_tag;
            rd_tgt   = pu_tgt;
            rd_ctr   = pu_ctr;
        end
`endif
        lk_hit_d   = rd_valid && (rd_tag == lk_tag);
        lk_taken_d = lk_hit_d && rd_ctr[CTR_W-1];
        lk_tgt_d   = lk_hit_d ? rd_tgt : '0;
    end

    logic              hit_q, taken_q;
    logic [ADDR_W-1:0] tgt_q;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            hit_q   <= 1'b0;
            taken_q <= 1'b0;
            tgt_q   <= '0;
        end else if (bus.w_ce) begin
            if (bus.w_flush) begin
                hit_q   <= 1'b0;
                taken_q <= 1'b0;
                tgt_q   <= '0;
            end else begin
                hit_q   <= lk_hit_d;
                taken_q <= lk_taken_d;
                tgt_q   <= lk_tgt_d;
            end
        end
    end

    assign bus.r_lk_hit    = hit_q;
    assign bus.r_lk_taken  = taken_q;
    assign bus.r_lk_target = tgt_q;
endmodule
